// File: rtl/sub_arb_seq_pkg.sv
// Shared definitions for the two-requester nibble-serial subtractor.
// Holds the controller state encoding, the slice width and a helper that
// turns an operand width into the number of nibble passes it needs.
package sub_arb_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nibble_count(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/sub_arb_seq_sub4_slice.sv
// sub4_slice: purely combinational 4-bit subtractor with borrow chaining.
// Ports:
//   a, b  - minuend / subtrahend nibble
//   bin   - borrow into this nibble
//   diff  - (a - b - bin) modulo 16
//   bout  - 1 when a < b + bin
module sub4_slice
  import sub_arb_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             bin,
  output logic [NIB_W-1:0] diff,
  output logic             bout
);

  logic [NIB_W:0] full;

  // One extra bit catches the wrap-around: a negative result sets the MSB,
  // which is exactly the borrow out of the nibble.
  always_comb begin
    full = {1'b0, a} - {1'b0, b} - {{NIB_W{1'b0}}, bin};
    diff = full[NIB_W-1:0];
    bout = full[NIB_W];
  end

endmodule

// File: rtl/sub_arb_seq.sv
// sub_arb_seq: two requesters share a single 4-bit subtract slice. A winning
// request is captured, then processed one nibble per cycle LSB first, and the
// result is held in DONE until the consumer takes it.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid[1:0]        - request valid per requester
//   req_ready[1:0]        - one-hot accept, only while idle
//   req_a0/req_b0         - requester 0 minuend / subtrahend
//   req_a1/req_b1         - requester 1 minuend / subtrahend
//   rsp_valid/rsp_ready   - result handshake
//   rsp_id                - which requester owns the result
//   rsp_diff/rsp_borrow   - A - B mod 2^WIDTH and final borrow (A < B)
// WIDTH must be a multiple of 4 and at least 8.
module sub_arb_seq
  import sub_arb_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_diff,
  output logic             rsp_borrow
);

  localparam int NIBS = nibble_count(WIDTH);
  localparam int CW   = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [CW-1:0] LAST_K = CW'(NIBS - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             rsp_borrow_q, rsp_borrow_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [1:0]       grant;
  logic             accept;
  logic [NIB_W-1:0] sl_a, sl_b, sl_diff;
  logic             sl_bin, sl_bout;

  // Arbitration: a lone requester wins; on a tie the one not served last
  // wins. last_q resets to 1 so requester 0 takes the first tie.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // req_ready is gated by rst_n so it reads 00 for the whole reset window.
  assign req_ready = (state_q == IDLE && rst_n) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);

  // Pick the nibble currently being worked on; the chain starts with no
  // borrow and afterwards uses the registered borrow of the previous nibble.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int i = 0; i < NIBS; i++) begin
      if (cnt_q == CW'(i)) begin
        sl_a = a_q[i*NIB_W +: NIB_W];
        sl_b = b_q[i*NIB_W +: NIB_W];
      end
    end
    sl_bin = (cnt_q == '0) ? 1'b0 : borrow_q;
  end

  sub4_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .bin  (sl_bin),
    .diff (sl_diff),
    .bout (sl_bout)
  );

  // Controller next state plus datapath updates.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    borrow_d     = borrow_q;
    diff_d       = diff_q;
    rsp_borrow_d = rsp_borrow_q;
    id_d         = id_q;
    last_d       = last_q;
    a_d          = a_q;
    b_d          = b_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = RUN;
          cnt_d    = '0;
          borrow_d = 1'b0;
          id_d     = req_ready[1];
          last_d   = req_ready[1];
          a_d      = req_ready[1] ? req_a1 : req_a0;
          b_d      = req_ready[1] ? req_b1 : req_b0;
        end
      end
      RUN: begin
        for (int i = 0; i < NIBS; i++) begin
          if (cnt_q == CW'(i)) diff_d[i*NIB_W +: NIB_W] = sl_diff;
        end
        borrow_d = sl_bout;
        if (cnt_q == LAST_K) begin
          rsp_borrow_d = sl_bout;
          cnt_d        = '0;
          state_d      = DONE;
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      diff_q       <= '0;
      rsp_borrow_q <= 1'b0;
      id_q         <= 1'b0;
      last_q       <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      borrow_q     <= borrow_d;
      diff_q       <= diff_d;
      rsp_borrow_q <= rsp_borrow_d;
      id_q         <= id_d;
      last_q       <= last_d;
      a_q          <= a_d;
      b_q          <= b_d;
    end
  end

  assign rsp_valid  = (state_q == DONE);
  assign rsp_id     = id_q;
  assign rsp_diff   = diff_q;
  assign rsp_borrow = rsp_borrow_q;

endmodule

// File: tb/tb_sub_arb_seq.sv
// Directed bench for sub_arb_seq (WIDTH=16): reset values, single requests,
// round-robin ties, response back-pressure, reset abort and operand capture.
module tb_sub_arb_seq;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a0, req_b0, req_a1, req_b1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_diff;
  logic        rsp_borrow;

  int tests;
  int fails;

  sub_arb_seq #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_diff   (rsp_diff),
    .rsp_borrow (rsp_borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request at a falling edge, note the accept, let the rising
  // edge happen, then drop valid for whichever requester was accepted.
  task automatic issue(input logic [1:0] valid, input logic [15:0] a0, input logic [15:0] b0,
                       input logic [15:0] a1, input logic [15:0] b1, output logic [1:0] ready_seen);
    @(negedge clk);
    req_valid = valid;
    req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
    #1 ready_seen = req_ready;
    @(posedge clk);
    #1 req_valid = req_valid & ~ready_seen;
  endtask

  // Count falling edges after the handshake until rsp_valid; -1 on timeout.
  task automatic wait_rsp(output int cycles, output logic busy_ready);
    cycles = -1;
    busy_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) busy_ready = 1'b1;
      if (rsp_valid === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b want 0", rsp_valid); end
    tests++; if (req_ready !== 2'b00) begin fails++; $display("[TB] FAIL reset_ready: got %b want 00", req_ready); end
    tests++; if (rsp_diff !== 16'h0000) begin fails++; $display("[TB] FAIL reset_diff: got %h want 0000", rsp_diff); end
    tests++; if (rsp_borrow !== 1'b0) begin fails++; $display("[TB] FAIL reset_borrow: got %b want 0", rsp_borrow); end
    tests++; if (rsp_id !== 1'b0) begin fails++; $display("[TB] FAIL reset_id: got %b want 0", rsp_id); end
    req_valid = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [1:0] rdy; int cyc; logic busy;
    issue(2'b01, 16'h1234, 16'h0FFF, 16'h0000, 16'h0000, rdy);
    tests++; if (rdy !== 2'b01) begin fails++; $display("[TB] FAIL basic_ready: got %b want 01", rdy); end
    wait_rsp(cyc, busy);
    // handshake cycle counted as cycle 0: rsp_valid first seen in cycle 5
    tests++; if (cyc != 5) begin fails++; $display("[TB] FAIL basic_latency: got %0d want 5", cyc); end
    tests++; if (rsp_diff !== 16'h0235) begin fails++; $display("[TB] FAIL basic_diff: got %h want 0235", rsp_diff); end
    tests++; if (rsp_borrow !== 1'b0) begin fails++; $display("[TB] FAIL basic_borrow: got %b want 0", rsp_borrow); end
    tests++; if (rsp_id !== 1'b0) begin fails++; $display("[TB] FAIL basic_id: got %b want 0", rsp_id); end
    accept_rsp();
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_valid_drop: got %b want 0", rsp_valid); end
    tests++; if (rsp_diff !== 16'h0235) begin fails++; $display("[TB] FAIL basic_hold: got %h want 0235", rsp_diff); end
  endtask

  task automatic test_borrow();
    logic [1:0] rdy; int cyc; logic busy;
    issue(2'b10, 16'h0000, 16'h0000, 16'h0000, 16'h0001, rdy);
    tests++; if (rdy !== 2'b10) begin fails++; $display("[TB] FAIL borrow_ready: got %b want 10", rdy); end
    wait_rsp(cyc, busy);
    tests++; if (cyc != 5) begin fails++; $display("[TB] FAIL borrow_latency: got %0d want 5", cyc); end
    tests++; if (rsp_diff !== 16'hFFFF) begin fails++; $display("[TB] FAIL borrow_diff: got %h want ffff", rsp_diff); end
    tests++; if (rsp_borrow !== 1'b1) begin fails++; $display("[TB] FAIL borrow_flag: got %b want 1", rsp_borrow); end
    tests++; if (rsp_id !== 1'b1) begin fails++; $display("[TB] FAIL borrow_id: got %b want 1", rsp_id); end
    accept_rsp();
  endtask

  task automatic test_round_robin();
    logic [1:0] rdy; int cyc; logic busy;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b11, 16'h8000, 16'h8000, 16'h0010, 16'h0001, rdy);
    tests++; if (rdy !== 2'b01) begin fails++; $display("[TB] FAIL rr_first_grant: got %b want 01", rdy); end
    wait_rsp(cyc, busy);
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rr_busy_ready: got %b want 0", busy); end
    tests++; if (rsp_id !== 1'b0) begin fails++; $display("[TB] FAIL rr_first_id: got %b want 0", rsp_id); end
    tests++; if (rsp_diff !== 16'h0000) begin fails++; $display("[TB] FAIL rr_first_diff: got %h want 0000", rsp_diff); end
    tests++; if (rsp_borrow !== 1'b0) begin fails++; $display("[TB] FAIL rr_first_borrow: got %b want 0", rsp_borrow); end
    accept_rsp();
    // requester 1 has been waiting the whole time
    issue(req_valid, req_a0, req_b0, req_a1, req_b1, rdy);
    tests++; if (rdy !== 2'b10) begin fails++; $display("[TB] FAIL rr_second_grant: got %b want 10", rdy); end
    wait_rsp(cyc, busy);
    tests++; if (rsp_id !== 1'b1) begin fails++; $display("[TB] FAIL rr_second_id: got %b want 1", rsp_id); end
    tests++; if (rsp_diff !== 16'h000F) begin fails++; $display("[TB] FAIL rr_second_diff: got %h want 000f", rsp_diff); end
    accept_rsp();
    issue(2'b11, 16'h0003, 16'h0001, 16'h0009, 16'h0002, rdy);
    tests++; if (rdy !== 2'b01) begin fails++; $display("[TB] FAIL rr_third_grant: got %b want 01", rdy); end
    req_valid = 2'b00;
    wait_rsp(cyc, busy);
    tests++; if (rsp_diff !== 16'h0002) begin fails++; $display("[TB] FAIL rr_third_diff: got %h want 0002", rsp_diff); end
    accept_rsp();
  endtask

  task automatic test_backpressure();
    logic [1:0] rdy; int cyc; logic busy;
    issue(2'b01, 16'h0005, 16'h0003, 16'h0000, 16'h0000, rdy);
    req_valid = 2'b01;
    wait_rsp(cyc, busy);
    tests++; if (cyc != 5) begin fails++; $display("[TB] FAIL bp_latency: got %0d want 5", cyc); end
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_valid c%0d: got %b want 1", i, rsp_valid); end
      tests++; if (rsp_diff !== 16'h0002) begin fails++; $display("[TB] FAIL bp_diff c%0d: got %h want 0002", i, rsp_diff); end
      tests++; if (req_ready !== 2'b00) begin fails++; $display("[TB] FAIL bp_ready c%0d: got %b want 00", i, req_ready); end
    end
    accept_rsp();
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_released: got %b want 0", rsp_valid); end
    tests++; if (req_ready !== 2'b01) begin fails++; $display("[TB] FAIL bp_idle_ready: got %b want 01", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_abort();
    logic [1:0] rdy; int cyc; logic busy; logic seen;
    issue(2'b01, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, rdy);
    req_valid = 2'b01;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL abort_valid: got %b want 0", rsp_valid); end
    tests++; if (req_ready !== 2'b00) begin fails++; $display("[TB] FAIL abort_ready: got %b want 00", req_ready); end
    tests++; if (rsp_diff !== 16'h0000) begin fails++; $display("[TB] FAIL abort_diff: got %h want 0000", rsp_diff); end
    tests++; if (rsp_borrow !== 1'b0) begin fails++; $display("[TB] FAIL abort_borrow: got %b want 0", rsp_borrow); end
    repeat (2) @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("[TB] FAIL abort_no_rsp: got %b want 0", seen); end
    issue(2'b11, 16'h00FF, 16'h0100, 16'h0020, 16'h0010, rdy);
    tests++; if (rdy !== 2'b01) begin fails++; $display("[TB] FAIL abort_grant: got %b want 01", rdy); end
    req_valid = 2'b00;
    wait_rsp(cyc, busy);
    tests++; if (rsp_diff !== 16'hFFFF) begin fails++; $display("[TB] FAIL abort_next_diff: got %h want ffff", rsp_diff); end
    tests++; if (rsp_borrow !== 1'b1) begin fails++; $display("[TB] FAIL abort_next_borrow: got %b want 1", rsp_borrow); end
    accept_rsp();
  endtask

  task automatic test_capture();
    logic [1:0] rdy; int cyc; logic busy;
    issue(2'b10, 16'h0000, 16'h0000, 16'h7000, 16'h0123, rdy);
    req_a1 = 16'hFFFF; req_b1 = 16'h0000; req_a0 = 16'h1111; req_b0 = 16'h2222;
    wait_rsp(cyc, busy);
    tests++; if (rsp_diff !== 16'h6EDD) begin fails++; $display("[TB] FAIL capture_diff: got %h want 6edd", rsp_diff); end
    tests++; if (rsp_borrow !== 1'b0) begin fails++; $display("[TB] FAIL capture_borrow: got %b want 0", rsp_borrow); end
    tests++; if (rsp_id !== 1'b1) begin fails++; $display("[TB] FAIL capture_id: got %b want 1", rsp_id); end
    accept_rsp();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req_valid = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_borrow();
    test_round_robin();
    test_backpressure();
    test_reset_abort();
    test_capture();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sub_arb_seq.md
SUB_ARB_SEQ -- requirements
Module: sub_arb_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 2, per-requester request valid, bit i = requester i.
REQ-005 SHALL have port req_ready, output, 2, per-requester accept; at most one bit high.
REQ-006 SHALL have ports req_a0 / req_b0, input, WIDTH each, requester 0 minuend / subtrahend.
REQ-007 SHALL have ports req_a1 / req_b1, input, WIDTH each, requester 1 minuend / subtrahend.
REQ-008 SHALL have port rsp_valid, output, 1, result valid.
REQ-009 SHALL have port rsp_ready, input, 1, result accept.
REQ-010 SHALL have port rsp_id, output, 1, index of the requester that owns the result.
REQ-011 SHALL have port rsp_diff, output, WIDTH, A minus B modulo 2^WIDTH.
REQ-012 SHALL have port rsp_borrow, output, 1, final borrow, 1 iff A < B unsigned.

Function
REQ-013 SHALL share one 4-bit subtract slice between two requesters, processing operands nibble-serially LSB first.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on request handshake, RUN->DONE after the last nibble, DONE->IDLE on rsp_valid&&rsp_ready.
REQ-015 SHALL assert req_ready only in IDLE, combinationally, to the granted requester only.
REQ-016 Grant rule: single valid requester wins; if both are valid, the requester not granted last wins (round-robin); last-grant pointer updates only on handshake.
REQ-017 SHALL capture A, B and the requester id on the handshake cycle (req_valid[i]&&req_ready[i]); later input changes SHALL NOT affect the operation.
REQ-018 Requesters SHALL hold req_valid and operands stable until accepted; the block SHALL NOT drop a pending request.
REQ-019 In RUN, nibble index k SHALL count 0..WIDTH/4-1, one nibble per cycle; borrow-in for nibble 0 SHALL be 0 and for nibble k SHALL be the registered borrow-out of nibble k-1.
REQ-020 Each RUN cycle SHALL write diff nibble k into the result register; the borrow of the last nibble SHALL become rsp_borrow.
REQ-021 Latency: rsp_valid SHALL rise WIDTH/4+1 cycles after the handshake edge (5 cycles for WIDTH=16).
REQ-022 In DONE, rsp_valid SHALL stay 1 and rsp_id/rsp_diff/rsp_borrow SHALL stay stable until rsp_ready is sampled high.
REQ-023 SHALL NOT accept a new request in the same cycle as a response handshake; the earliest next accept is the cycle after return to IDLE.
REQ-024 rsp_diff/rsp_borrow SHALL be undefined-free (registered) and hold the last result after DONE->IDLE until overwritten.

Reset
REQ-025 While rst_n is low: state=IDLE, nibble counter=0, borrow register=0, result register=0, rsp_valid=0, rsp_id=0, rsp_borrow=0, last-grant pointer=1 (requester 0 wins the first tie), req_ready=2'b00.
REQ-026 Reset assertion in RUN or DONE SHALL abort the operation with no response produced; the first grant after release SHALL follow REQ-025 values.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the nibble width constant 4.
REQ-028 The 4-bit subtract with borrow-in/borrow-out SHALL be a separate combinational sub-module sub4_slice, instantiated once.

Verification
REQ-029 Req0 A=0x1234 B=0x0FFF -> rsp_diff=0x0235, rsp_borrow=0, rsp_id=0, rsp_valid at handshake+5.
REQ-030 Req1 A=0x0000 B=0x0001 -> rsp_diff=0xFFFF, rsp_borrow=1, rsp_id=1.
REQ-031 Both requesters valid after reset (A0=0x8000 B0=0x8000; A1=0x0010 B1=0x0001) -> first rsp_id=0 diff=0x0000 borrow=0, then rsp_id=1 diff=0x000F; a third tie is granted to requester 0.
REQ-032 rsp_ready held low 3 cycles in DONE -> rsp_valid and data stable, req_ready=00 throughout; accept only on the 4th cycle.
REQ-033 rst_n pulsed low during RUN nibble 2 -> all outputs at reset values immediately; no rsp_valid; the next request completes correctly.
REQ-034 Operands changed one cycle after the handshake -> the result reflects the captured values only.
